// File: rtl/alu_pkg.sv
// Shared definitions for the time-shared ALU arbiter: op encodings and default widths.
package alu_pkg;

    localparam int ALU_OP_W   = 3;
    localparam int ALU_DATA_W = 32;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011
    } alu_op_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The search begins one past ptr and wraps;
// the first asserted request wins. Produces a one-hot grant plus its index.
module rr_arbiter #(
    parameter int N = 3,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);

    // Walk the requests in rotated order and pick the first one set.
    always_comb begin
        int   p;
        logic found;
        gnt   = '0;
        idx   = '0;
        any   = 1'b0;
        p     = 0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            p = int'(ptr) + 1 + k;
            if (p >= N) p = p - N;
            if (p >= N) p = p - N;
            if (!found && req[p]) begin
                found  = 1'b1;
                gnt[p] = 1'b1;
                idx    = p[W-1:0];
            end
        end
        any = found;
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU among NUM_REQ requesters. Grants round-robin,
// captures the ALU output into a single owner-tagged result register, and
// supports drain-and-accept in the same cycle for one op per cycle.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = ALU_DATA_W
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ-1:0][ALU_OP_W-1:0]   req_op,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]     req_src1,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]     req_src2,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    input  logic [NUM_REQ-1:0]                 rsp_ready,
    output logic [DATA_W-1:0]                  rsp_result,
    output logic                               rsp_zero,
    output logic [ALU_OP_W-1:0]                alu_control,
    output logic [DATA_W-1:0]                  alu_src1,
    output logic [DATA_W-1:0]                  alu_src2,
    input  logic [DATA_W-1:0]                  alu_result,
    input  logic                               alu_zero
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    owner;
    logic               out_valid;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;
    logic               slot_free;
    logic               accept;

    rr_arbiter #(.N(NUM_REQ), .W(ID_W)) u_rr (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    // The slot is free when empty or when the current owner is draining it now.
    always_comb begin
        slot_free = !out_valid || rsp_ready[owner];
        req_ready = slot_free ? gnt : '0;
        accept    = gnt_any && slot_free;
    end

    // Route the granted requester onto the shared ALU; park it at zero when idle.
    always_comb begin
        alu_control = ALU_ADD;
        alu_src1    = '0;
        alu_src2    = '0;
        if (gnt_any) begin
            alu_control = req_op[gnt_idx];
            alu_src1    = req_src1[gnt_idx];
            alu_src2    = req_src2[gnt_idx];
        end
    end

    // Result register and round-robin pointer; the pointer moves only on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            owner      <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rr_ptr     <= ID_W'(NUM_REQ - 1);
        end else if (accept) begin
            out_valid  <= 1'b1;
            owner      <= gnt_idx;
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            rr_ptr     <= gnt_idx;
        end else if (out_valid && rsp_ready[owner]) begin
            out_valid  <= 1'b0;
        end
    end

    // Only the owner sees a valid response; out_valid clears asynchronously on reset.
    always_comb begin
        rsp_valid        = '0;
        rsp_valid[owner] = out_valid;
    end

    a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready));
    a_rsp_onehot : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(rsp_valid));
    a_rsp_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (rsp_valid[owner] && !rsp_ready[owner]) |=> $stable(rsp_result));

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural model of the shared ALU.
module tb_alu_share_arb;
    import alu_pkg::*;

    localparam int N  = 3;
    localparam int DW = 32;

    logic                         clk;
    logic                         rst_n;
    logic [N-1:0]                 req_valid;
    logic [N-1:0]                 req_ready;
    logic [N-1:0][ALU_OP_W-1:0]   req_op;
    logic [N-1:0][DW-1:0]         req_src1;
    logic [N-1:0][DW-1:0]         req_src2;
    logic [N-1:0]                 rsp_valid;
    logic [N-1:0]                 rsp_ready;
    logic [DW-1:0]                rsp_result;
    logic                         rsp_zero;
    logic [ALU_OP_W-1:0]          alu_control;
    logic [DW-1:0]                alu_src1;
    logic [DW-1:0]                alu_src2;
    logic [DW-1:0]                alu_result;
    logic                         alu_zero;

    int total = 0;
    int bad   = 0;

    alu_share_arb #(.NUM_REQ(N), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_src1    (req_src1),
        .req_src2    (req_src2),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .alu_control (alu_control),
        .alu_src1    (alu_src1),
        .alu_src2    (alu_src2),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero)
    );

    // Shared ALU model
    always_comb begin
        case (alu_control)
            ALU_ADD: alu_result = alu_src1 + alu_src2;
            ALU_SUB: alu_result = alu_src1 - alu_src2;
            ALU_AND: alu_result = alu_src1 & alu_src2;
            ALU_OR:  alu_result = alu_src1 | alu_src2;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_src1  = '0;
        req_src2  = '0;
        rsp_ready = '0;
        #3;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_rsp_result", 64'(rsp_result), 64'h0);
        chk("rst_rsp_zero", 64'(rsp_zero), 64'h0);
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        #9 rst_n = 1'b1;
        tick();
        chk("idle_alu_ctl", 64'(alu_control), 64'h0);
        chk("idle_alu_src1", 64'(alu_src1), 64'h0);

        // single ADD 5+7 from requester 0
        rsp_ready   = 3'b111;
        req_valid   = 3'b001;
        req_op[0]   = 3'b000;
        req_src1[0] = 32'd5;
        req_src2[0] = 32'd7;
        #1;
        chk("add_req_ready", 64'(req_ready), 64'b001);
        chk("add_alu_src1", 64'(alu_src1), 64'd5);
        tick();
        req_valid = '0;
        chk("add_rsp_valid", 64'(rsp_valid), 64'b001);
        chk("add_rsp_result", 64'(rsp_result), 64'd12);
        chk("add_rsp_zero", 64'(rsp_zero), 64'h0);
        tick();
        chk("add_drained", 64'(rsp_valid), 64'h0);

        // SUB 9-9 then 0-1 from requester 1 (second one is drain+accept)
        req_valid   = 3'b010;
        req_op[1]   = 3'b001;
        req_src1[1] = 32'd9;
        req_src2[1] = 32'd9;
        #1;
        chk("sub0_req_ready", 64'(req_ready), 64'b010);
        tick();
        chk("sub0_rsp_result", 64'(rsp_result), 64'h0);
        chk("sub0_rsp_zero", 64'(rsp_zero), 64'h1);
        chk("sub0_rsp_valid", 64'(rsp_valid), 64'b010);
        req_src1[1] = 32'd0;
        req_src2[1] = 32'd1;
        #1;
        chk("sub1_req_ready", 64'(req_ready), 64'b010);
        tick();
        req_valid = '0;
        chk("sub1_rsp_result", 64'(rsp_result), 64'hFFFF_FFFF);
        chk("sub1_rsp_zero", 64'(rsp_zero), 64'h0);
        tick();

        // illegal op 110 from requester 2
        req_valid   = 3'b100;
        req_op[2]   = 3'b110;
        req_src1[2] = 32'd1234;
        req_src2[2] = 32'd5678;
        #1;
        chk("ill_req_ready", 64'(req_ready), 64'b100);
        chk("ill_alu_ctl", 64'(alu_control), 64'b110);
        tick();
        req_valid = '0;
        chk("ill_rsp_valid", 64'(rsp_valid), 64'b100);
        chk("ill_rsp_result", 64'(rsp_result), 64'h0);
        chk("ill_rsp_zero", 64'(rsp_zero), 64'h1);
        tick();

        // round-robin: all valid, results i*10+1, accept order 0,1,2,0,1,2
        for (int i = 0; i < N; i++) begin
            req_op[i]   = 3'b000;
            req_src1[i] = 32'(i * 10);
            req_src2[i] = 32'd1;
        end
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("rr_ready_%0d", k), 64'(req_ready), 64'(3'b001 << (k % 3)));
            tick();
            chk($sformatf("rr_valid_%0d", k), 64'(rsp_valid), 64'(3'b001 << (k % 3)));
            chk($sformatf("rr_result_%0d", k), 64'(rsp_result), 64'((k % 3) * 10 + 1));
        end
        req_valid = '0;
        tick();
        chk("rr_drained", 64'(rsp_valid), 64'h0);

        // backpressure: requester 1 holds result 42 for 3 cycles
        req_valid   = 3'b010;
        req_src1[1] = 32'd40;
        req_src2[1] = 32'd2;
        req_op[1]   = 3'b000;
        tick();
        rsp_ready   = 3'b101;
        req_valid   = 3'b101;
        req_src1[0] = 32'd100;
        req_src2[0] = 32'd1;
        req_src1[2] = 32'd200;
        req_src2[2] = 32'd2;
        req_op[2]   = 3'b000;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp_ready_%0d", k), 64'(req_ready), 64'h0);
            chk($sformatf("bp_valid_%0d", k), 64'(rsp_valid), 64'b010);
            chk($sformatf("bp_result_%0d", k), 64'(rsp_result), 64'd42);
            tick();
        end
        rsp_ready = 3'b111;
        #1;
        chk("bp_release_ready", 64'(req_ready), 64'b100);
        tick();
        req_valid = '0;
        chk("bp_next_valid", 64'(rsp_valid), 64'b100);
        chk("bp_next_result", 64'(rsp_result), 64'd202);
        tick();

        // async reset while requester 1 holds a result
        req_valid   = 3'b010;
        req_src1[1] = 32'd3;
        req_src2[1] = 32'd4;
        tick();
        req_valid = '0;
        rsp_ready = '0;
        chk("ar_before", 64'(rsp_valid), 64'b010);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("ar_rsp_result", 64'(rsp_result), 64'h0);
        #2 rst_n = 1'b1;
        rsp_ready = 3'b111;
        req_valid = 3'b111;
        req_src1[0] = 32'd0;
        req_src2[0] = 32'd1;
        #1;
        chk("ar_first_ready", 64'(req_ready), 64'b001);
        tick();
        req_valid = '0;
        chk("ar_first_valid", 64'(rsp_valid), 64'b001);
        chk("ar_first_result", 64'(rsp_result), 64'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Round-robin arbiter that time-shares one combinational ALU (3-bit op: ADD/SUB/AND/OR) among NUM_REQ requesters, e.g. address-gen, branch-compare and CSR units.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Results are held in a single output register tagged with the owner ID.
- Throughput is one op per cycle; latency is one cycle from accept to response.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- DATA_W, 32, operand/result width.
- ID_W, $clog2(NUM_REQ), owner-ID width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  [NUM_REQ]  request pending, per requester.
- req_ready  out  [NUM_REQ]  request accepted this cycle (one-hot or zero).
- req_op  in  [NUM_REQ][3]  op code per requester: 000 ADD, 001 SUB, 010 AND, 011 OR.
- req_src1  in  [NUM_REQ][DATA_W]  operand 1.
- req_src2  in  [NUM_REQ][DATA_W]  operand 2.
- rsp_valid  out  [NUM_REQ]  result available for requester i (at most one bit set).
- rsp_ready  in  [NUM_REQ]  requester i consumes result.
- rsp_result  out  DATA_W  registered ALU result (shared bus; qualified by rsp_valid).
- rsp_zero  out  1  registered zero flag.
- alu_control  out  3  to shared ALU.
- alu_src1  out  DATA_W  to shared ALU.
- alu_src2  out  DATA_W  to shared ALU.
- alu_result  in  DATA_W  from shared ALU (combinational).
- alu_zero  in  1  from shared ALU.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, owner=0, rsp_result=0, rsp_zero=0.
  - rr_ptr=NUM_REQ-1, so requester 0 has top priority first.
  - All rsp_valid=0 immediately, not waiting for a clock edge.
- slot_free = !out_valid || rsp_ready[owner].
- Grant (combinational):
  - Search starts at index (rr_ptr+1) mod NUM_REQ and wraps. The first set req_valid wins.
  - gnt is one-hot, or zero if no req_valid is set.
- req_ready[i] = gnt[i] && slot_free. req_ready depends on req_valid (permitted). Requesters must hold op/src stable while valid && !ready.
- ALU drive:
  - alu_control/alu_src1/alu_src2 = granted requester's fields.
  - When no grant, drive 000/0/0.
- Accept edge (any req_ready high):
  - out_valid<=1, owner<=index, rsp_result<=alu_result, rsp_zero<=alu_zero.
  - rr_ptr<=index.
- rr_ptr changes only on accept. Unaccepted grants (slot busy) do not move the pointer.
- Drain without accept: out_valid<=0 when rsp_ready[owner] is high and no new accept occurs. rsp_result/rsp_zero hold their last value.
- Simultaneous drain + accept in the same cycle is allowed and gives back-to-back 1/cycle throughput. The new owner may equal the old one.
- Output hold: rsp_valid[owner]=out_valid. While the output is not consumed, rsp_result/rsp_zero/owner stay stable.
- rsp_ready[j] for j != owner, or while out_valid=0, is ignored.
- Op codes 100..111: passed through unchanged. The ALU yields 0, so rsp_result=0 and rsp_zero=1. No error signalled.
- Arithmetic is the ALU's, DATA_W wrap-around (SUB 0-1 = all ones). The arbiter never alters data.
- Reset mid-operation: a pending result is discarded with no response. Requesters must reissue.
- Fairness: with all requesters continuously valid and drained, each is granted exactly once every NUM_REQ cycles.
- Assertions:
  - $onehot0(req_ready).
  - $onehot0(rsp_valid).
  - rsp_result stable while rsp_valid[owner] && !rsp_ready[owner].

Decomposition:
- alu_pkg:
  - alu_op_e enum (ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011).
  - ALU_OP_W=3, DATA_W default.
- Sub-module rr_arbiter #(N): req vector + ptr in, one-hot gnt + encoded index out, pure combinational, reusable elsewhere.
- The top holds the output register, ptr register, handshakes and muxes.

Test Plan:
- Single ADD: req0 valid, op=000, 5+7, all rsp_ready=1. req_ready[0]=1 at cycle 0; cycle 1 gives rsp_valid=001, rsp_result=12, rsp_zero=0.
- SUB edges: req1 op=001 9-9 gives result 0, zero=1. Next, 0-1 gives 32'hFFFF_FFFF, zero=0.
- Round-robin: all three valid every cycle, rsp_ready all 1. Accepts go 0,1,2,0,1,2 on consecutive cycles; rsp_valid one-hot trails grant by 1 cycle.
- Backpressure: req1 result 42 with rsp_ready[1]=0 for 3 cycles while req0/req2 are valid. No req_ready is asserted and rsp_result holds 42. In the cycle rsp_ready[1]=1, req2 is accepted and its result appears the next cycle.
- Illegal op: req2 op=3'b110, 1234/5678. Response is rsp_result=0, rsp_zero=1.
- Async reset mid-op: drop rst_n between clock edges while rsp_valid[1]=1. rsp_valid goes to 0 immediately. After release with all requesters valid, requester 0 is accepted first.
